// File: rtl/pong_pkg.sv
// pong_pkg: screen/paddle geometry shared by the ball and paddle blocks,
// the ball state encoding, and helpers for the signed geometry domain.
package pong_pkg;

   localparam int H_ACTIVE     = 640;
   localparam int V_ACTIVE     = 480;
   localparam int WALL_MARGIN  = 10;
   localparam int BALL_HALF    = 2;
   localparam int SPEED        = 2;
   localparam int PAD_L_X      = 22;
   localparam int PAD_R_X      = 617;
   localparam int PAD_HALF_H   = 16;
   localparam int SERVE_FRAMES = 60;

   typedef logic [9:0] coord_t;

   typedef enum logic [1:0] {
      SERVE_WAIT = 2'd0,
      PLAY       = 2'd1,
      SCORED     = 2'd2
   } ball_state_t;

   // Absolute value in the 11-bit signed domain used for all geometry.
   function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
      return v[10] ? -v : v;
   endfunction

   // Zero-extend a 10-bit screen coordinate so differences never wrap.
   function automatic logic signed [10:0] to_s11(input logic [9:0] v);
      return signed'({1'b0, v});
   endfunction

endpackage

// File: rtl/pong_ball_engine_if.sv
// pong_ball_engine_if: raster and paddle inputs, ball position, score pulses
// and ball pixel colour of the ball engine.
interface pong_ball_engine_if;
   import pong_pkg::*;

   coord_t hcount;
   coord_t vcount;
   logic   vsync;
   coord_t pad_l_y;
   coord_t pad_r_y;
   coord_t ball_x;
   coord_t ball_y;
   logic   score_l;
   logic   score_r;
   logic   serving;
   logic   r;
   logic   g;
   logic   b;

   modport master (
      output hcount, vcount, vsync, pad_l_y, pad_r_y,
      input  ball_x, ball_y, score_l, score_r, serving, r, g, b
   );

   modport slave (
      input  hcount, vcount, vsync, pad_l_y, pad_r_y,
      output ball_x, ball_y, score_l, score_r, serving, r, g, b
   );

endinterface

// File: rtl/vsync_tick.sv
// vsync_tick: brings raw active-low vsync into the pixel clock domain and
// emits a one-cycle frame tick on each falling edge. Reset parks the whole
// chain at the idle (high) level so no stale edge survives a reset.
module vsync_tick (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_vsync,
   output logic o_frame_tick
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   // Two-stage synchroniser followed by one delay stage for edge detection.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= i_vsync;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_frame_tick = r_prev & ~r_sync2;

endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball position/direction, serve/score state machine,
// wall and paddle collision, and the registered ball pixel. Everything
// advances once per frame tick derived from vsync.
module pong_ball_engine #(
   parameter int H_ACTIVE     = pong_pkg::H_ACTIVE,
   parameter int V_ACTIVE     = pong_pkg::V_ACTIVE,
   parameter int BALL_HALF    = pong_pkg::BALL_HALF,
   parameter int SPEED        = pong_pkg::SPEED,
   parameter int WALL_MARGIN  = pong_pkg::WALL_MARGIN,
   parameter int PAD_L_X      = pong_pkg::PAD_L_X,
   parameter int PAD_R_X      = pong_pkg::PAD_R_X,
   parameter int PAD_HALF_H   = pong_pkg::PAD_HALF_H,
   parameter int SERVE_FRAMES = pong_pkg::SERVE_FRAMES
) (
   input  logic              i_clk,
   input  logic              i_reset,
   pong_ball_engine_if.slave io_bus
);

   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   // Geometry constants in the signed domain used by the collision tests.
   localparam logic signed [10:0] L_SPD   = 11'(SPEED);
   localparam logic signed [10:0] L_BH    = 11'(BALL_HALF);
   localparam logic signed [10:0] L_YMIN  = 11'(WALL_MARGIN);
   localparam logic signed [10:0] L_YMAX  = 11'(V_ACTIVE - 1 - WALL_MARGIN);
   localparam logic signed [10:0] L_XMAX  = 11'(H_ACTIVE - 1);
   localparam logic signed [10:0] L_PLX   = 11'(PAD_L_X);
   localparam logic signed [10:0] L_PRX   = 11'(PAD_R_X);
   localparam logic signed [10:0] L_REACH = 11'(PAD_HALF_H + BALL_HALF);

   localparam logic [9:0] C_X      = 10'(H_ACTIVE / 2);
   localparam logic [9:0] C_Y      = 10'(V_ACTIVE / 2);
   localparam logic [9:0] C_LHIT_X = 10'(PAD_L_X + BALL_HALF + 1);
   localparam logic [9:0] C_RHIT_X = 10'(PAD_R_X - BALL_HALF - 1);
   localparam logic [CNT_W-1:0] C_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

   pong_pkg::ball_state_t r_state, w_state_nx;
   logic [9:0]       r_x, r_y, w_x_nx, w_y_nx;
   logic             r_dir_x, r_dir_y, w_dir_x_nx, w_dir_y_nx;   // 1 = +
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic             r_score_l, r_score_r, w_score_l_nx, w_score_r_nx;
   logic             r_pix;

   logic                w_tick;
   logic signed [10:0]  w_x, w_y, w_nx, w_ny, w_pl, w_pr, w_hc, w_vc;
   logic                w_hit_l, w_hit_r, w_miss_l, w_miss_r, w_draw;

   vsync_tick u_tick (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_vsync      (io_bus.vsync),
      .o_frame_tick (w_tick)
   );

   assign w_x  = pong_pkg::to_s11(r_x);
   assign w_y  = pong_pkg::to_s11(r_y);
   assign w_pl = pong_pkg::to_s11(io_bus.pad_l_y);
   assign w_pr = pong_pkg::to_s11(io_bus.pad_r_y);
   assign w_hc = pong_pkg::to_s11(io_bus.hcount);
   assign w_vc = pong_pkg::to_s11(io_bus.vcount);

   assign w_nx = r_dir_x ? (w_x + L_SPD) : (w_x - L_SPD);
   assign w_ny = r_dir_y ? (w_y + L_SPD) : (w_y - L_SPD);

   // A paddle only catches the ball on the frame it crosses the face, so a
   // ball already behind the face keeps going and is scored as a miss.
   assign w_hit_l = !r_dir_x && (w_nx - L_BH <= L_PLX) && (w_x - L_BH > L_PLX - L_SPD)
                    && (pong_pkg::abs11(w_y - w_pl) <= L_REACH);
   assign w_hit_r =  r_dir_x && (w_nx + L_BH >= L_PRX) && (w_x + L_BH < L_PRX + L_SPD)
                    && (pong_pkg::abs11(w_y - w_pr) <= L_REACH);
   assign w_miss_l = (w_nx - L_BH) < 11'sd0;
   assign w_miss_r = (w_nx + L_BH) > L_XMAX;

   // Next-state, next-position and score pulse decode; only acts on a tick.
   always_comb begin
      w_state_nx   = r_state;
      w_x_nx       = r_x;
      w_y_nx       = r_y;
      w_dir_x_nx   = r_dir_x;
      w_dir_y_nx   = r_dir_y;
      w_cnt_nx     = r_cnt;
      w_score_l_nx = 1'b0;
      w_score_r_nx = 1'b0;
      if (w_tick) begin
         unique case (r_state)
            pong_pkg::SERVE_WAIT: begin
               w_x_nx = C_X;
               w_y_nx = C_Y;
               if (r_cnt == C_SERVE_LAST) begin
                  w_cnt_nx   = '0;
                  w_state_nx = pong_pkg::PLAY;
               end else begin
                  w_cnt_nx = r_cnt + 1'b1;
               end
            end
            pong_pkg::PLAY: begin
               if (w_ny < L_YMIN) begin
                  w_y_nx     = L_YMIN[9:0];
                  w_dir_y_nx = 1'b1;
               end else if (w_ny > L_YMAX) begin
                  w_y_nx     = L_YMAX[9:0];
                  w_dir_y_nx = 1'b0;
               end else begin
                  w_y_nx = w_ny[9:0];
               end
               if (w_hit_l) begin
                  w_x_nx     = C_LHIT_X;
                  w_dir_x_nx = 1'b1;
               end else if (w_hit_r) begin
                  w_x_nx     = C_RHIT_X;
                  w_dir_x_nx = 1'b0;
               end else if (w_miss_l || w_miss_r) begin
                  // Ball freezes where it left the field until recentred.
                  w_y_nx       = r_y;
                  w_dir_y_nx   = r_dir_y;
                  w_score_r_nx = w_miss_l;
                  w_score_l_nx = !w_miss_l;
                  w_state_nx   = pong_pkg::SCORED;
               end else begin
                  w_x_nx = w_nx[9:0];
               end
            end
            pong_pkg::SCORED: begin
               // dir_x still points at the side that conceded, which is
               // where the next serve goes, so it is simply kept.
               w_x_nx     = C_X;
               w_y_nx     = C_Y;
               w_cnt_nx   = '0;
               w_state_nx = pong_pkg::SERVE_WAIT;
            end
            default: w_state_nx = pong_pkg::SERVE_WAIT;
         endcase
      end
   end

   // Ball state registers and one-cycle score pulses.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= pong_pkg::SERVE_WAIT;
         r_x       <= C_X;
         r_y       <= C_Y;
         r_dir_x   <= 1'b1;
         r_dir_y   <= 1'b1;
         r_cnt     <= '0;
         r_score_l <= 1'b0;
         r_score_r <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_x       <= w_x_nx;
         r_y       <= w_y_nx;
         r_dir_x   <= w_dir_x_nx;
         r_dir_y   <= w_dir_y_nx;
         r_cnt     <= w_cnt_nx;
         r_score_l <= w_score_l_nx;
         r_score_r <= w_score_r_nx;
      end
   end

   assign w_draw = (r_state != pong_pkg::SCORED)
                   && (pong_pkg::abs11(w_hc - w_x) <= L_BH)
                   && (pong_pkg::abs11(w_vc - w_y) <= L_BH);

   // Ball pixel, one clock behind the raster position.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_pix <= 1'b0;
      else         r_pix <= w_draw;
   end

   assign io_bus.ball_x  = r_x;
   assign io_bus.ball_y  = r_y;
   assign io_bus.score_l = r_score_l;
   assign io_bus.score_r = r_score_r;
   assign io_bus.serving = (r_state == pong_pkg::SERVE_WAIT);
   assign io_bus.r       = r_pix;
   assign io_bus.g       = r_pix;
   assign io_bus.b       = r_pix;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: drives short synthetic frames and raster probes; a
// frame-level ball model produces expected positions/pulses/pixels which are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_pong_ball_engine;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pong_ball_engine_if bus ();

   pong_ball_engine dut (
      .i_clk   (clk),
      .i_reset (rst),
      .io_bus  (bus)
   );

   typedef struct { int x; int y; bit srv; bit sl; bit sr; } exp_t;
   typedef struct { int h; int v; bit rgb; } pix_vec_t;

   exp_t     pos_q[$];
   bit       pix_q[$];
   pix_vec_t pv[14];

   int n_cmp = 0;
   int n_bad = 0;

   // frame-level reference model
   int m_x, m_y, m_st, m_cnt;   // m_st: 0 serve, 1 play, 2 scored
   bit m_dx, m_dy;
   bit last_hl, last_sr;
   logic d_sr;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic m_reset();
      m_x = 320; m_y = 240; m_dx = 1'b1; m_dy = 1'b1; m_st = 0; m_cnt = 0;
   endtask

   task automatic m_step(input int pl, input int pr, output bit sl, output bit sr, output bit hl);
      int nx, ny, ty;
      bit tdy;
      sl = 0; sr = 0; hl = 0;
      if (m_st == 0) begin
         if (m_cnt == 59) begin m_cnt = 0; m_st = 1; end
         else m_cnt++;
      end else if (m_st == 2) begin
         m_x = 320; m_y = 240; m_cnt = 0; m_st = 0;
      end else begin
         nx = m_dx ? m_x + 2 : m_x - 2;
         ny = m_dy ? m_y + 2 : m_y - 2;
         ty = ny; tdy = m_dy;
         if (ny < 10) begin ty = 10; tdy = 1; end
         else if (ny > 469) begin ty = 469; tdy = 0; end
         if (!m_dx && nx - 2 <= 22 && m_x - 2 > 20 && iabs(m_y - pl) <= 18) begin
            m_x = 25; m_dx = 1; hl = 1; m_y = ty; m_dy = tdy;
         end else if (m_dx && nx + 2 >= 617 && m_x + 2 < 619 && iabs(m_y - pr) <= 18) begin
            m_x = 614; m_dx = 0; m_y = ty; m_dy = tdy;
         end else if (nx - 2 < 0) begin
            sr = 1; m_st = 2;
         end else if (nx + 2 > 639) begin
            sl = 1; m_st = 2;
         end else begin
            m_x = nx; m_y = ty; m_dy = tdy;
         end
      end
   endtask

   // One frame: vsync fall, check the tick update and pulse width, then
   // probe one raster point near the ball.
   task automatic do_tick(input int pl, input int pr);
      exp_t e;
      bit sl, sr, hl;
      int dx, dy;
      logic [9:0] hc, vc;
      @(negedge clk);
      bus.pad_l_y = 10'(pl);
      bus.pad_r_y = 10'(pr);
      bus.vsync   = 1'b0;
      m_step(pl, pr, sl, sr, hl);
      last_hl = hl; last_sr = sr;
      e = '{m_x, m_y, (m_st == 0), sl, sr};
      pos_q.push_back(e);
      repeat (3) @(posedge clk);
      @(negedge clk);
      e = pos_q.pop_front();
      cmp("tick_x", bus.ball_x, e.x);
      cmp("tick_y", bus.ball_y, e.y);
      cmp("tick_serving", bus.serving, e.srv);
      cmp("tick_score_l", bus.score_l, e.sl);
      cmp("tick_score_r", bus.score_r, e.sr);
      d_sr = bus.score_r;
      @(negedge clk);
      cmp("pulse_len", {bus.score_l, bus.score_r}, 0);
      bus.vsync = 1'b1;
      repeat (3) @(negedge clk);
      dx = int'($urandom_range(6, 0)) - 3;
      dy = int'($urandom_range(6, 0)) - 3;
      hc = 10'(m_x + dx);
      vc = 10'(m_y + dy);
      bus.hcount = hc;
      bus.vcount = vc;
      pix_q.push_back((m_st != 2) && iabs(int'(hc) - m_x) <= 2 && iabs(int'(vc) - m_y) <= 2);
      @(negedge clk);
      cmp("tick_pix", {bus.r, bus.g, bus.b}, pix_q.pop_front() ? 7 : 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      int  phase;
      bit  pre_wall, wall_follow, wall_seen;
      pv = '{'{318, 240, 1}, '{322, 240, 1}, '{317, 240, 0}, '{323, 240, 0},
             '{320, 238, 1}, '{320, 242, 1}, '{320, 237, 0}, '{320, 243, 0},
             '{318, 238, 1}, '{322, 242, 1}, '{317, 243, 0}, '{1023, 240, 0},
             '{320, 1023, 0}, '{0, 0, 0}};
      rst = 1'b1;
      bus.vsync = 1'b1;
      bus.hcount = 10'd320; bus.vcount = 10'd240;
      bus.pad_l_y = 10'd240; bus.pad_r_y = 10'd240;
      m_reset();
      last_hl = 0; last_sr = 0; d_sr = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      cmp("rst_x", bus.ball_x, 320);
      cmp("rst_y", bus.ball_y, 240);
      cmp("rst_serving", bus.serving, 1);
      cmp("rst_scores", {bus.score_l, bus.score_r}, 0);
      cmp("rst_rgb", {bus.r, bus.g, bus.b}, 0);
      rst = 1'b0;
      @(negedge clk);
      cmp("rgb_after_rst", {bus.r, bus.g, bus.b}, 7);

      // pixel table at the serve position, pipelined through the queue
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (pix_q.size() > 0)
            cmp($sformatf("pix_tbl_%0d", i - 1), {bus.r, bus.g, bus.b}, pix_q.pop_front() ? 7 : 0);
         bus.hcount = 10'(pv[i].h);
         bus.vcount = 10'(pv[i].v);
         pix_q.push_back(pv[i].rgb);
      end
      @(negedge clk);
      cmp("pix_tbl_13", {bus.r, bus.g, bus.b}, pix_q.pop_front() ? 7 : 0);

      // serve: ticks 1..59 hold, tick 60 enters play, tick 61 moves
      for (int i = 1; i <= 59; i++) do_tick(240, 240);
      cmp("serve_hold", bus.serving, 1);
      do_tick(240, 240);
      cmp("serve_done", bus.serving, 0);
      do_tick(240, 240);
      cmp("tick61_x", bus.ball_x, 322);
      cmp("tick61_y", bus.ball_y, 242);

      // rally: right paddle tracks; left tracks until the first left hit,
      // then sits 40 rows away so the ball is missed on the left
      phase = 0; wall_follow = 0; wall_seen = 0;
      for (int t = 0; t < 3000 && phase < 3; t++) begin
         pre_wall = (m_st == 1) && (m_y == 11) && !m_dy;
         do_tick((phase == 0) ? m_y : m_y + 40, m_y);
         if (wall_follow) begin
            cmp("wall_next_y", bus.ball_y, 12);
            wall_follow = 0; wall_seen = 1;
         end
         if (pre_wall) begin
            cmp("wall_clamp_y", bus.ball_y, 10);
            wall_follow = 1;
         end
         if (last_hl && phase == 0) begin
            cmp("lpad_hit_x", bus.ball_x, 25);
            cmp("lpad_no_score", d_sr, 0);
            phase = 1;
         end
         if (last_sr && phase == 1) begin
            cmp("miss_pulse_r", d_sr, 1);
            cmp("miss_frozen_x", bus.ball_x, 2);
            cmp("miss_not_serving", bus.serving, 0);
            do_tick(240, 240);
            cmp("recentre_x", bus.ball_x, 320);
            cmp("recentre_y", bus.ball_y, 240);
            cmp("recentre_serving", bus.serving, 1);
            for (int i = 1; i <= 60; i++) do_tick(240, 240);
            do_tick(240, 240);
            cmp("serve_toward_left_x", bus.ball_x, 318);
            phase = 3;
         end
      end
      cmp("rally_complete", phase, 3);
      cmp("wall_case_seen", wall_seen, 1);

      // reset mid-play with a vsync edge still in the synchroniser
      repeat (3) do_tick(m_y, m_y);
      @(negedge clk);
      bus.vsync = 1'b0;
      @(negedge clk);
      bus.vsync = 1'b1;
      rst = 1'b1;
      bus.hcount = 10'd320; bus.vcount = 10'd240;
      @(negedge clk);
      cmp("mid_rst_x", bus.ball_x, 320);
      cmp("mid_rst_y", bus.ball_y, 240);
      cmp("mid_rst_serving", bus.serving, 1);
      cmp("mid_rst_scores", {bus.score_l, bus.score_r}, 0);
      cmp("mid_rst_rgb", {bus.r, bus.g, bus.b}, 0);
      rst = 1'b0;
      m_reset();
      @(negedge clk);
      cmp("mid_rst_redraw", {bus.r, bus.g, bus.b}, 7);
      for (int i = 1; i <= 59; i++) do_tick(240, 240);
      cmp("post_rst_serving", bus.serving, 1);
      do_tick(240, 240);
      cmp("post_rst_serve_done", bus.serving, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
